// File: rtl/stream_pkg.sv
// Shared definitions for the stream capture block: FSM state encoding.
package stream_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// A read and a write to the same address in one cycle return the old data.
module sdp_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/stream_capture.sv
// Captures one stream frame into a local buffer after an arm edge and reports
// the captured length, length mismatch and buffer overflow.
module stream_capture
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           samples,
    input  logic                  arm,
    input  logic [DATA_WIDTH-1:0] stream_i_tdata,
    input  logic                  stream_i_tvalid,
    input  logic                  stream_i_tlast,
    output logic                  stream_i_tready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  done,
    output logic                  len_err,
    output logic                  overflow
);

    localparam logic [ADDR_WIDTH:0] LAST_IDX = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_e                state_q;
    logic                  arm_old_q;
    logic                  arm_hold_q;
    logic [31:0]           samples_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    logic                  done_q;
    logic                  len_err_q;
    logic                  overflow_q;
    logic                  arm_evt;
    logic                  beat_acc;

    assign stream_i_tready = (state_q == CAPTURE);
    assign beat_acc        = stream_i_tvalid && stream_i_tready;
    assign count_d         = count_q + 1'b1;
    // arm_hold_q masks an arm level that was already high while in reset
    assign arm_evt         = arm && !arm_old_q && !arm_hold_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            arm_old_q  <= 1'b0;
            arm_hold_q <= arm;
            samples_q  <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            len_err_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            arm_old_q <= arm;
            if (!arm) begin
                arm_hold_q <= 1'b0;
            end
            case (state_q)
                IDLE, DONE: begin
                    if (arm_evt) begin
                        state_q    <= CAPTURE;
                        samples_q  <= samples;
                        count_q    <= '0;
                        done_q     <= 1'b0;
                        len_err_q  <= 1'b0;
                        overflow_q <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (beat_acc) begin
                        count_q <= count_d;
                        if (stream_i_tlast) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            len_err_q <= (32'(count_d) != samples_q);
                        end else if (count_q == LAST_IDX) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            len_err_q  <= 1'b1;
                            overflow_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign count    = count_q;
    assign done     = done_q;
    assign len_err  = len_err_q;
    assign overflow = overflow_q;

    sdp_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_buf (
        .clk    (clk),
        .we_i   (beat_acc),
        .waddr_i(count_q[ADDR_WIDTH-1:0]),
        .wdata_i(stream_i_tdata),
        .raddr_i(rd_addr),
        .rdata_o(rd_data)
    );

endmodule

// File: tb/tb_stream_capture.sv
// Directed bench for stream_capture with a 16-entry buffer.
module tb_stream_capture;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   samples;
    logic          arm;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [AW:0]   count;
    logic          done;
    logic          len_err;
    logic          overflow;

    int n_total = 0;
    int n_pass  = 0;

    stream_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .samples        (samples),
        .arm            (arm),
        .stream_i_tdata (tdata),
        .stream_i_tvalid(tvalid),
        .stream_i_tlast (tlast),
        .stream_i_tready(tready),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .count          (count),
        .done           (done),
        .len_err        (len_err),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic last);
        tvalid = 1'b1;
        tdata  = d;
        tlast  = last;
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd_addr = a;
        tick();
        check(tag, 64'(rd_data), 64'(exp));
    endtask

    initial begin
        logic [19:0] vpat;
        int idx;
        int cyc;
        reset = 1'b1; samples = 32'd0; arm = 1'b0;
        tdata = '0; tvalid = 1'b0; tlast = 1'b0; rd_addr = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_tready", 64'(tready), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_len_err", 64'(len_err), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);

        // matched frame
        samples = 32'd8;
        arm_pulse();
        check("m_tready", 64'(tready), 64'd1);
        for (int i = 0; i < 8; i++) beat(DW'(i), i == 7);
        check("m_done", 64'(done), 64'd1);
        check("m_count", 64'(count), 64'd8);
        check("m_len_err", 64'(len_err), 64'd0);
        check("m_overflow", 64'(overflow), 64'd0);
        check("m_tready_off", 64'(tready), 64'd0);
        read_check("m_rd5", 4'd5, 16'd5);

        // short frame, then beats held off
        arm_pulse();
        for (int i = 0; i < 4; i++) beat(DW'(100 + i), i == 3);
        check("s_done", 64'(done), 64'd1);
        check("s_count", 64'(count), 64'd4);
        check("s_len_err", 64'(len_err), 64'd1);
        tvalid = 1'b1; tdata = 16'hBEEF;
        check("s_tready_after", 64'(tready), 64'd0);
        tick(); tick();
        tvalid = 1'b0;
        check("s_count_hold", 64'(count), 64'd4);
        read_check("s_rd4_untouched", 4'd4, 16'd4);
        read_check("s_rd3", 4'd3, 16'd103);

        // overflow
        samples = 32'd100;
        arm_pulse();
        for (int i = 0; i < 20; i++) begin
            tvalid = 1'b1; tdata = DW'(200 + i); tlast = 1'b0;
            tick();
        end
        tvalid = 1'b0;
        check("o_count", 64'(count), 64'd16);
        check("o_overflow", 64'(overflow), 64'd1);
        check("o_done", 64'(done), 64'd1);
        check("o_len_err", 64'(len_err), 64'd1);
        check("o_tready", 64'(tready), 64'd0);
        read_check("o_rd0", 4'd0, 16'd200);
        read_check("o_rd15", 4'd15, 16'd215);

        // bubbles on tvalid
        samples = 32'd8;
        arm_pulse();
        vpat = 20'b1011_0010_1101_1001_0110;
        idx = 0; cyc = 0;
        while (idx < 8 && cyc < 100) begin
            tvalid = vpat[cyc % 20] || (cyc >= 20);
            tdata  = DW'(300 + idx);
            tlast  = (idx == 7);
            tick();
            if (tvalid) idx++;
            cyc++;
        end
        tvalid = 1'b0; tlast = 1'b0;
        check("b_done", 64'(done), 64'd1);
        check("b_count", 64'(count), 64'd8);
        check("b_len_err", 64'(len_err), 64'd0);
        for (int i = 0; i < 8; i++) read_check("b_rd", AW'(i), DW'(300 + i));

        // arm edge during capture is ignored
        arm_pulse();
        for (int i = 0; i < 3; i++) beat(DW'(400 + i), 1'b0);
        arm_pulse();
        tick();
        check("a_count_kept", 64'(count), 64'd3);
        check("a_tready", 64'(tready), 64'd1);
        for (int i = 3; i < 8; i++) beat(DW'(400 + i), i == 7);
        check("a_count", 64'(count), 64'd8);
        check("a_len_err", 64'(len_err), 64'd0);
        read_check("a_rd3", 4'd3, 16'd403);

        // reset mid-frame, then a clean frame
        arm_pulse();
        beat(16'd500, 1'b0);
        beat(16'd501, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("r_tready", 64'(tready), 64'd0);
        check("r_count", 64'(count), 64'd0);
        check("r_done", 64'(done), 64'd0);
        arm_pulse();
        for (int i = 0; i < 8; i++) beat(DW'(600 + i), i == 7);
        check("r_count8", 64'(count), 64'd8);
        check("r_len_err", 64'(len_err), 64'd0);
        read_check("r_rd2", 4'd2, 16'd602);

        // arm held through reset, then samples=0 always flags len_err
        samples = 32'd0;
        arm = 1'b1; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("h_tready_held", 64'(tready), 64'd0);
        arm = 1'b0;
        tick();
        arm_pulse();
        check("h_tready_rearm", 64'(tready), 64'd1);
        beat(16'd777, 1'b1);
        check("z_count", 64'(count), 64'd1);
        check("z_len_err", 64'(len_err), 64'd1);
        check("z_done", 64'(done), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
